// File: rtl/umem_pkg.sv
// Shared mask codes, scheduler state and lane helpers for the unified-memory scheduler.
package umem_pkg;
    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    function automatic logic [3:0] laneBe(input logic [1:0] mask, input logic [1:0] offs);
        case (mask)
            MASK_B:  laneBe = 4'b0001 << offs;
            MASK_H:  laneBe = offs[1] ? 4'b1100 : 4'b0011;
            default: laneBe = 4'b1111;
        endcase
    endfunction

    // Mask 11 has no legal alignment, so it is reported the same way as a misaligned access.
    function automatic logic misaligned(input logic [1:0] mask, input logic [1:0] offs);
        case (mask)
            MASK_B:  misaligned = 1'b0;
            MASK_H:  misaligned = offs[0];
            MASK_W:  misaligned = |offs;
            default: misaligned = 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/umem_lane_fmt.sv
// Lane formatter: load lane extraction with sign extension, store lane shift and RMW merge.
// Latency: purely combinational.
// Backpressure: none; the scheduler qualifies every input and output.
module umem_lane_fmt
    import umem_pkg::*;
(
    input  logic [1:0]  ldMask,
    input  logic [1:0]  ldOffs,
    input  logic        ldSext,
    input  logic [31:0] ldWord,
    output logic [31:0] ldData,
    input  logic [1:0]  stMask,
    input  logic [1:0]  stOffs,
    input  logic [31:0] stData,
    input  logic [31:0] oldWord,
    output logic [31:0] stShift,
    output logic [3:0]  stBe,
    output logic [31:0] stMerged
);
    logic [31:0] ldShifted;

    assign ldShifted = ldWord >> {ldOffs, 3'b000};
    assign stBe      = laneBe(stMask, stOffs);

    always_comb begin
        case (ldMask)
            MASK_B:  ldData = {{24{ldSext & ldShifted[7]}}, ldShifted[7:0]};
            MASK_H:  ldData = {{16{ldSext & ldShifted[15]}}, ldShifted[15:0]};
            default: ldData = ldWord;
        endcase
    end

    always_comb begin
        case (stMask)
            MASK_B:  stShift = {24'd0, stData[7:0]} << {stOffs, 3'b000};
            MASK_H:  stShift = {16'd0, stData[15:0]} << {stOffs[1], 4'b0000};
            default: stShift = stData;
        endcase
    end

    always_comb begin
        stMerged = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (stBe[i]) stMerged[8*i +: 8] = stShift[8*i +: 8];
        end
    end
endmodule

// File: rtl/umem_sched.sv
// Shares one single-port synchronous RAM between fetch and data ports; UMEM_RMW_EN selects read-modify-write sub-word stores.
// Latency: fetch/load data and store ack 1 cycle after grant; RMW sub-word store ack 2 cycles after grant.
// Backpressure: combinational gnt, at most one per cycle; the loser holds req; nothing is granted while an RMW write completes.
module umem_sched
    import umem_pkg::*;
#(
    parameter int AW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_mask,
    input  logic          d_sext,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata
);
`ifdef UMEM_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t        state;
    logic [SW-1:0] starveCnt;
    logic          dLoadQ, dSextQ;
    logic [1:0]    dMaskQ, dOffsQ;
    logic [AW-1:0] dAddrQ;
    logic [31:0]   dWdataQ;

    logic          idle, fetchWins, dErrNow, dRmwStart, inRmw;
    logic [31:0]   ldData, stShift, stMerged;
    logic [3:0]    stBe;
    logic          unusedBits;

    assign unusedBits = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2]};

    // Gating with reset keeps every output low while reset is held, even with requests pending.
    assign inRmw     = (state == RMW_WR);
    assign idle      = reset && !inRmw;
    assign fetchWins = (starveCnt == SW'(STARVE_MAX));
    assign d_gnt     = idle && d_req && !(fetchWins && if_req);
    assign if_gnt    = idle && if_req && !d_gnt;
    assign dErrNow   = misaligned(d_mask, d_addr[1:0]);
    assign dRmwStart = RMW_EN && d_gnt && !dErrNow && d_we && (d_mask != MASK_W);

    umem_lane_fmt u_lane_fmt (
        .ldMask   (dMaskQ),
        .ldOffs   (dOffsQ),
        .ldSext   (dSextQ),
        .ldWord   (mem_rdata),
        .ldData   (ldData),
        .stMask   (inRmw ? dMaskQ  : d_mask),
        .stOffs   (inRmw ? dOffsQ  : d_addr[1:0]),
        .stData   (inRmw ? dWdataQ : d_wdata),
        .oldWord  (mem_rdata),
        .stShift  (stShift),
        .stBe     (stBe),
        .stMerged (stMerged)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        if (inRmw) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = dAddrQ;
            mem_wdata = stMerged;
            mem_be    = 4'b1111;
        end else if (d_gnt && !dErrNow) begin
            mem_en   = 1'b1;
            mem_addr = d_addr[AW+1:2];
            mem_be   = 4'b1111;
            if (d_we && !dRmwStart) begin
                mem_we    = 1'b1;
                mem_wdata = stShift;
                mem_be    = RMW_EN ? 4'b1111 : stBe;
            end
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[AW+1:2];
            mem_be   = 4'b1111;
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : 32'd0;
    assign d_rdata  = (d_rvalid && dLoadQ && !d_err) ? ldData : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            dLoadQ    <= 1'b0;
            dSextQ    <= 1'b0;
            dMaskQ    <= MASK_B;
            dOffsQ    <= 2'b00;
            dAddrQ    <= '0;
            dWdataQ   <= '0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= (d_gnt && !dRmwStart) || inRmw;
            d_err     <= d_gnt && dErrNow;
            if (!if_req || if_gnt) begin
                starveCnt <= '0;
            end else if (!fetchWins) begin
                starveCnt <= starveCnt + SW'(1);
            end
            if (d_gnt) begin
                dLoadQ  <= !d_we;
                dSextQ  <= d_sext;
                dMaskQ  <= d_mask;
                dOffsQ  <= d_addr[1:0];
                dAddrQ  <= d_addr[AW+1:2];
                dWdataQ <= d_wdata;
            end
            state <= dRmwStart ? RMW_WR : IDLE;
        end
    end
endmodule

// File: tb/tb_umem_sched.sv
// Bench for umem_sched: directed vector table, hand-written corner sequences, and randomized traffic against a reference model.
module tb_umem_sched;
    import umem_pkg::*;

    localparam int AW   = 8;
    localparam int SMAX = 4;
`ifdef UMEM_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_rvalid;
    logic [31:0]   if_addr, if_rdata;
    logic          d_req, d_we, d_sext, d_gnt, d_rvalid, d_err;
    logic [1:0]    d_mask;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata = 32'd0;

    logic [31:0]   ram [0:255];
    logic          pokeEn = 1'b0;
    logic [7:0]    pokeAddr = 8'd0;
    logic [31:0]   pokeDat = 32'd0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    umem_sched #(.AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_mask(d_mask), .d_sext(d_sext), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM with byte enables; the bench preloads it through the poke port.
    always @(posedge clk) begin
        if (pokeEn) begin
            ram[pokeAddr] <= pokeDat;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  mask;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] v);
        @(negedge clk);
        pokeEn = 1'b1; pokeAddr = 8'(a); pokeDat = v;
        @(negedge clk);
        pokeEn = 1'b0;
    endtask

    function automatic bit refErr(input int m, input int off);
        return (m == 3) || (m == 1 && off % 2 != 0) || (m == 2 && off % 4 != 0);
    endfunction

    function automatic int refBytes(input int m);
        return (m == 0) ? 1 : (m == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] w, input int m, input bit s, input int off);
        int     n = refBytes(m);
        longint v = 0;
        for (int b = 0; b < n; b++) v += longint'((w >> (8 * (off + b))) & 32'hFF) << (8 * b);
        if (s && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] old, input logic [31:0] wd, input int m, input int off);
        logic [31:0] r = old;
        for (int b = 0; b < refBytes(m); b++) r[8 * (off + b) +: 8] = wd[8 * b +: 8];
        return r;
    endfunction

    task automatic idleIn();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_sext = 1'b0; d_mask = MASK_W;
    endtask

    // One data transaction: grant in the drive cycle, then a bounded wait for the response.
    task automatic dTxn(input vec_t v, input string nm);
        int lat, expLat;
        bit memExp;
        @(negedge clk);
        d_req = 1'b1; d_we = v.we; d_mask = v.mask; d_sext = v.sext; d_addr = v.addr; d_wdata = v.wdata;
        #1;
        memExp = !refErr(int'(v.mask), int'(v.addr[1:0]));
        expLat = (RMW && v.we && v.mask != MASK_W && memExp) ? 2 : 1;
        chk($sformatf("%s gnt", nm), d_gnt, 1'b1);
        chk($sformatf("%s mem_en", nm), mem_en, memExp);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        lat = 1;
        while (!d_rvalid && lat < 5) begin
            @(negedge clk); #1; lat++;
        end
        chk($sformatf("%s latency", nm), d_rvalid ? lat : 0, expLat);
        chk($sformatf("%s rdata", nm), d_rdata, v.expData);
        chk($sformatf("%s err", nm), d_err, v.expErr);
    endtask

    initial begin
        logic [5:0]  expDpat;
        logic [31:0] fetchExp [3];
        logic [31:0] refMem [16];
        int  sc, blockAt, dDue, fDue;
        logic [31:0] dExp, fExp;
        logic        dExpErr, expD, expF;
        bit          hasD, hasF;
        logic        rWe, rSext;
        logic [1:0]  rMask;
        logic [31:0] rAddr, rWdata, rFa;

        reset = 1'b0; idleIn(); d_addr = 0; d_wdata = 0; if_addr = 0;
        vecs[0]  = '{1'b0, MASK_B, 1'b1, 32'h6, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{1'b0, MASK_B, 1'b0, 32'h7, 32'h0,        32'h00000080, 1'b0};
        vecs[2]  = '{1'b0, MASK_B, 1'b1, 32'h5, 32'h0,        32'h0000007F, 1'b0};
        vecs[3]  = '{1'b0, MASK_H, 1'b1, 32'h4, 32'h0,        32'h00007F01, 1'b0};
        vecs[4]  = '{1'b0, MASK_H, 1'b1, 32'h6, 32'h0,        32'hFFFF80FF, 1'b0};
        vecs[5]  = '{1'b0, MASK_H, 1'b0, 32'h6, 32'h0,        32'h000080FF, 1'b0};
        vecs[6]  = '{1'b0, MASK_W, 1'b0, 32'h4, 32'h0,        32'h80FF7F01, 1'b0};
        vecs[7]  = '{1'b0, MASK_W, 1'b0, 32'h2, 32'h0,        32'h00000000, 1'b1};
        vecs[8]  = '{1'b0, MASK_H, 1'b0, 32'h5, 32'h0,        32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 2'b11,  1'b0, 32'h4, 32'h0,        32'h00000000, 1'b1};
        vecs[10] = '{1'b1, MASK_H, 1'b0, 32'hA, 32'h1234BEEF, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, MASK_W, 1'b0, 32'h8, 32'h0,        32'hBEEF3344, 1'b0};
        vecs[12] = '{1'b1, MASK_B, 1'b0, 32'h9, 32'hFFFFFFAA, 32'h00000000, 1'b0};
        vecs[13] = '{1'b0, MASK_W, 1'b0, 32'h8, 32'h0,        32'hBEEFAA44, 1'b0};
        vecs[14] = '{1'b1, MASK_W, 1'b0, 32'h8, 32'hCAFEF00D, 32'h00000000, 1'b0};
        vecs[15] = '{1'b0, MASK_W, 1'b0, 32'h8, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[16] = '{1'b1, MASK_W, 1'b0, 32'h9, 32'h0BADF00D, 32'h00000000, 1'b1};
        vecs[17] = '{1'b0, MASK_B, 1'b1, 32'hB, 32'h0,        32'hFFFFFFCA, 1'b0};

        poke(0, 32'h00000013);
        poke(1, 32'h80FF7F01);
        poke(2, 32'h11223344);
        @(negedge clk);
        d_req = 1'b1; if_req = 1'b1; d_addr = 32'h4;
        #1;
        chk("reset d_gnt", d_gnt, 1'b0);
        chk("reset if_gnt", if_gnt, 1'b0);
        chk("reset mem_en", mem_en, 1'b0);
        chk("reset mem_be", mem_be, 4'b0000);
        chk("reset mem_addr/we/wdata", {mem_we, mem_addr, mem_wdata[22:0]}, 32'd0);
        chk("reset rvalids", {d_rvalid, if_rvalid, d_err}, 3'b000);
        chk("reset rdata", d_rdata | if_rdata, 32'd0);
        idleIn();
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < 18; i++) dTxn(vecs[i], $sformatf("vec%0d", i));

        // Half store over 0x11223344 at byte address 6.
        poke(1, 32'h11223344);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_mask = MASK_H; d_addr = 32'h6; d_wdata = 32'h0000BEEF;
        #1;
        chk("sh gnt", d_gnt, 1'b1);
        chk("sh mem_we", mem_we, !RMW);
        chk("sh mem_be", mem_be, RMW ? 4'b1111 : 4'b1100);
        @(negedge clk); idleIn(); #1;
        chk("sh cycle1 rvalid", d_rvalid, !RMW);
        if (RMW) begin
            chk("sh rmw mem_we", mem_we, 1'b1);
            chk("sh rmw mem_wdata", mem_wdata, 32'hBEEF3344);
            @(negedge clk); #1;
            chk("sh cycle2 rvalid", d_rvalid, 1'b1);
        end
        chk("sh ram", ram[1], 32'hBEEF3344);

        // Contention: fetch wins only after STARVE_MAX denials.
        expDpat = 6'b101111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            d_req = 1'b1; d_we = 1'b0; d_mask = MASK_W; d_addr = 32'h4; if_req = 1'b1; if_addr = 32'h0;
            #1;
            chk($sformatf("contend c%0d d_gnt", c), d_gnt, expDpat[c]);
            chk($sformatf("contend c%0d if_gnt", c), if_gnt, !expDpat[c]);
        end
        @(negedge clk); idleIn();

        // Pipelined fetch of words 0..2.
        fetchExp[0] = 32'h00000013; fetchExp[1] = 32'hBEEF3344; fetchExp[2] = 32'hCAFEF00D;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if_req = (c < 3); if_addr = 32'(c * 4);
            #1;
            if (c < 3) chk($sformatf("fetch%0d gnt", c), if_gnt, 1'b1);
            if (c > 0) begin
                chk($sformatf("fetch%0d rvalid", c - 1), if_rvalid, 1'b1);
                chk($sformatf("fetch%0d rdata", c - 1), if_rdata, fetchExp[c - 1]);
            end
        end

        // Reset in the cycle after a sub-word store grant.
        poke(3, 32'h55667788);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_mask = MASK_B; d_addr = 32'hC; d_wdata = 32'h99;
        #1;
        chk("rst-rmw gnt", d_gnt, 1'b1);
        @(negedge clk);
        reset = 1'b0; if_req = 1'b1; d_we = 1'b0;
        #1;
        chk("rst-rmw gnts", {d_gnt, if_gnt}, 2'b00);
        chk("rst-rmw mem_en/we", {mem_en, mem_we}, 2'b00);
        chk("rst-rmw rvalids", {d_rvalid, if_rvalid, d_err}, 3'b000);
        chk("rst-rmw rdata", d_rdata | if_rdata | mem_wdata, 32'd0);
        @(negedge clk); idleIn();
        @(negedge clk); reset = 1'b1; #1;
        chk("rst-rmw no ack a", d_rvalid, 1'b0);
        @(negedge clk); #1;
        chk("rst-rmw no ack b", d_rvalid, 1'b0);
        chk("rst-rmw ram", ram[3], RMW ? 32'h55667788 : 32'h55667799);

        // Randomized traffic against the reference model.
        for (int w = 0; w < 16; w++) begin
            refMem[w] = $urandom;
            poke(w, refMem[w]);
        end
        @(negedge clk);
        sc = 0; blockAt = -1; dDue = -1; fDue = -1; hasD = 0; hasF = 0;
        dExp = 0; fExp = 0; dExpErr = 0; rFa = 0;
        rWe = 0; rSext = 0; rMask = 0; rAddr = 0; rWdata = 0;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            if (!hasD && $urandom_range(0, 99) < 50) begin
                hasD = 1; rWe = 1'($urandom_range(0, 1)); rSext = 1'($urandom_range(0, 1));
                rMask = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                rAddr = 32'($urandom_range(0, 63)); rWdata = $urandom;
            end
            if (!hasF && $urandom_range(0, 99) < 50) begin
                hasF = 1; rFa = 32'($urandom_range(0, 15) * 4);
            end
            d_req = hasD; d_we = rWe; d_mask = rMask; d_sext = rSext; d_addr = rAddr; d_wdata = rWdata;
            if_req = hasF; if_addr = rFa;
            #1;
            chk("rnd d_rvalid", d_rvalid, dDue == t);
            if (dDue == t) begin
                chk("rnd d_rdata", d_rdata, dExp);
                chk("rnd d_err", d_err, dExpErr);
            end
            chk("rnd if_rvalid", if_rvalid, fDue == t);
            if (fDue == t) chk("rnd if_rdata", if_rdata, fExp);
            expD = (blockAt != t) && hasD && !(sc == SMAX && hasF);
            expF = (blockAt != t) && hasF && !expD;
            chk("rnd d_gnt", d_gnt, expD);
            chk("rnd if_gnt", if_gnt, expF);
            sc = (!hasF || expF) ? 0 : (sc < SMAX ? sc + 1 : sc);
            if (expD) begin
                dDue = t + 1; dExp = 0; dExpErr = 0;
                if (refErr(int'(rMask), int'(rAddr) % 4)) begin
                    dExpErr = 1;
                end else if (!rWe) begin
                    dExp = refLoad(refMem[rAddr / 4], int'(rMask), rSext, int'(rAddr) % 4);
                end else begin
                    refMem[rAddr / 4] = refStore(refMem[rAddr / 4], rWdata, int'(rMask), int'(rAddr) % 4);
                    if (RMW && refBytes(int'(rMask)) < 4) begin
                        dDue = t + 2; blockAt = t + 1;
                    end
                end
                hasD = 0;
            end
            if (expF) begin
                fExp = refMem[rFa / 4]; fDue = t + 1; hasF = 0;
            end
        end
        @(negedge clk); idleIn();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/umem_sched.md
# umem_sched

Single-port memory scheduler that shares one unified word-addressed synchronous RAM between the instruction-fetch port and the data port of the core. Each cycle it arbitrates between the two requesters and issues at most one memory command. It formats sub-word loads (lane select, sign extension) and sequences sub-word stores. It sits between the fetch/LSU stages and the RAM macro, replacing the separate combinational instruction and data ports.

## Interface
- AW, 8, RAM word-address width (RAM depth 2^AW words)
- STARVE_MAX, 4, consecutive fetch denials after which fetch wins arbitration
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address (bits [1:0] ignored)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_mask  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_sext  in  1  sign-extend sub-word load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data or store acknowledge
- d_rdata  out  32  formatted load data (0 for stores)
- d_err  out  1  misaligned/illegal, qualified by d_rvalid
- mem_en  out  1  RAM command valid
- mem_we  out  1  RAM write
- mem_addr  out  AW  RAM word address = addr[AW+1:2]
- mem_wdata  out  32  RAM write data
- mem_be  out  4  RAM byte enables
- mem_rdata  in  32  RAM read data, valid the cycle after a read command

## Operation
- States: IDLE (issuing), RMW_WR (completing a read-modify-write store).
- A request is accepted when req && gnt in the same cycle. gnt is combinational, and only one gnt is asserted per cycle. No gnt is asserted in RMW_WR.
- Arbitration in IDLE: data wins over fetch unless starve_cnt == STARVE_MAX; then fetch wins.
- starve_cnt increments when if_req is denied. It clears on fetch grant or when if_req is low. It saturates at STARVE_MAX.
- Alignment errors: half with addr[0]=1, word with addr[1:0]!=0, and mask 11 are all errors.
  - The request is accepted and no mem_en is issued.
  - Next cycle: d_rvalid=1, d_err=1, d_rdata=0.
- Load: read issued at grant. Next cycle, d_rdata is the lane selected by addr[1:0]/addr[1] from mem_rdata, zero-extended or sign-extended per d_sext.
- Word store: a single write with mem_be=1111. d_rvalid ack follows next cycle.
- Sub-word store: see Configuration.
- Fetch: read issued at grant. if_rvalid and if_rdata=mem_rdata follow next cycle.

## Timing
- Load and fetch latency: 1 cycle from grant to rvalid. Back-to-back grants every cycle are allowed.
- Store ack: 1 cycle after the write command.
- Reset values: all outputs 0, state IDLE, starve_cnt 0, pending-response flags 0.
- Reset asserted mid-RMW: the pending write is dropped and no ack is produced.
- Simultaneous if_req/d_req: exactly one gnt. The loser must hold its request.
- Requests arriving during RMW_WR are not granted and counted for starvation as denials.

## Configuration
- UMEM_RMW_EN defined: the RAM has no byte enables and mem_be is always 1111.
  - Sub-word store cycle 0: grant, issue a read.
  - Cycle 1 (RMW_WR): merge d_wdata into the read word at the selected lanes and issue the write.
  - Cycle 2: d_rvalid ack. The addr, mask and wdata latched at grant are used for the merge.
- UMEM_RMW_EN undefined: sub-word stores are a single write with lane-shifted mem_wdata and mem_be set to the selected lanes (byte: 0001<<addr[1:0]; half: 0011 or 1100). RMW_WR is never entered.

## Structure
- Package umem_pkg:
  - mask codes MASK_B/MASK_H/MASK_W
  - state enum
  - function for lane byte-enable generation
- Sub-module umem_lane_fmt (combinational):
  - load lane extraction and sign extension
  - store lane shift and merge
  - instantiated once, shared by load and store paths.

## Test plan
- Load byte: RAM[1]=0x80FF7F01, lb addr 0x6 with sext=1 → d_rdata=0xFFFFFFFF one cycle after grant; lbu addr 0x7 → 0x00000080.
- Store half: addr 0x6, d_wdata 0x0000BEEF over word 0x11223344 → RAM[1]=0xBEEF3344.
  - With UMEM_RMW_EN: ack at cycle 2.
  - Without UMEM_RMW_EN: mem_be=1100 and ack at cycle 1.
- Contention: if_req and d_req both held high for 6 cycles → d_gnt in cycles 0-3, if_gnt in cycle 4 (STARVE_MAX=4), d_gnt in cycle 5.
- Misaligned: word load at addr 0x2 → no mem_en; next cycle d_rvalid=1, d_err=1, d_rdata=0.
- Reset during RMW: assert reset in the RMW_WR cycle → no write to RAM, no ack, all outputs 0 while reset is low.
- Pipelined fetch: if_req held high with addresses 0,4,8 → if_rvalid on 3 consecutive cycles with RAM[0..2] in order.
